// File: rtl/id_pkg.sv
// Shared ID-stage definitions: immediate extension modes and skid-buffer occupancy states.
package id_pkg;

    localparam int IMM_MODE_W = 2;

    localparam logic [IMM_MODE_W-1:0] IMM_SIGN   = 2'b00;
    localparam logic [IMM_MODE_W-1:0] IMM_ZERO   = 2'b01;
    localparam logic [IMM_MODE_W-1:0] IMM_UPPER  = 2'b10;
    localparam logic [IMM_MODE_W-1:0] IMM_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_FULL  = 2'b10
    } occ_state_t;

endpackage : id_pkg

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: SIGN, ZERO, UPPER and BRANCH (sign-extended, shifted left 2).
module imm_extend_core
    import id_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]       imm,
    input  logic [IMM_MODE_W-1:0] mode,
    output logic [OUT_W-1:0]      ext_value
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] upper_ext;
    logic [OUT_W-1:0] branch_ext;

    // Bit-wise construction keeps every index in range for any legal IN_W/OUT_W pair.
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
            if (gi < IN_W) begin : g_low
                assign sign_ext[gi] = imm[gi];
                assign zero_ext[gi] = imm[gi];
            end else begin : g_high
                assign sign_ext[gi] = imm[IN_W-1];
                assign zero_ext[gi] = 1'b0;
            end
            if (gi >= PAD_W) begin : g_up
                assign upper_ext[gi] = imm[gi-PAD_W];
            end else begin : g_up_zero
                assign upper_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // Top two bits of the sign-extended value fall off the end.
    assign branch_ext = {sign_ext[OUT_W-3:0], 2'b00};

    always_comb begin
        ext_value = sign_ext;
        case (mode)
            IMM_SIGN:   ext_value = sign_ext;
            IMM_ZERO:   ext_value = zero_ext;
            IMM_UPPER:  ext_value = upper_ext;
            IMM_BRANCH: ext_value = branch_ext;
            default:    ext_value = sign_ext;
        endcase
    end

endmodule : imm_extend_core

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a 2-entry skid buffer (output reg + skid reg).
// Optional accepted-beat counter enabled by defining IMM_EXT_STATS_EN.
module imm_extend_pipe
    import id_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_imm,
    input  logic [IMM_MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic [15:0]           stat_count
);

    generate
        if (OUT_W <= IN_W) begin : g_bad_out_w
            $error("imm_extend_pipe: OUT_W must be greater than IN_W");
        end
        if (IN_W < 2) begin : g_bad_in_w
            $error("imm_extend_pipe: IN_W must be at least 2");
        end
    endgenerate

    occ_state_t state_reg;
    occ_state_t state_next;

    logic [OUT_W-1:0] or_data_reg;
    logic [TAG_W-1:0] or_tag_reg;
    logic [OUT_W-1:0] sr_data_reg;
    logic [TAG_W-1:0] sr_tag_reg;

    logic [OUT_W-1:0] ext_value;
    logic             in_accept;
    logic             out_drain;
    logic             or_load_in;
    logic             or_load_sr;
    logic             sr_load;

    // Extension happens before storage so both registers hold final operands.
    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm       (in_imm),
        .mode      (in_mode),
        .ext_value (ext_value)
    );

    // Both handshake outputs depend only on registered occupancy.
    assign in_ready  = (state_reg != OCC_FULL);
    assign out_valid = (state_reg != OCC_EMPTY);
    assign out_data  = or_data_reg;
    assign out_tag   = or_tag_reg;

    assign in_accept = in_valid && in_ready;
    assign out_drain = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= OCC_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        or_load_in = 1'b0;
        or_load_sr = 1'b0;
        sr_load    = 1'b0;
        case (state_reg)
            OCC_EMPTY: begin
                if (in_accept) begin
                    state_next = OCC_ONE;
                    or_load_in = 1'b1;
                end
            end
            OCC_ONE: begin
                case ({in_accept, out_drain})
                    2'b10: begin
                        state_next = OCC_FULL;
                        sr_load    = 1'b1;
                    end
                    2'b11: begin
                        state_next = OCC_ONE;
                        or_load_in = 1'b1;
                    end
                    2'b01: begin
                        state_next = OCC_EMPTY;
                    end
                    default: begin
                        state_next = OCC_ONE;
                    end
                endcase
            end
            OCC_FULL: begin
                if (out_drain) begin
                    state_next = OCC_ONE;
                    or_load_sr = 1'b1;
                end
            end
            default: begin
                state_next = OCC_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_data_reg <= '0;
            or_tag_reg  <= '0;
            sr_data_reg <= '0;
            sr_tag_reg  <= '0;
        end else begin
            if (or_load_in) begin
                or_data_reg <= ext_value;
                or_tag_reg  <= in_tag;
            end else if (or_load_sr) begin
                or_data_reg <= sr_data_reg;
                or_tag_reg  <= sr_tag_reg;
            end
            if (sr_load) begin
                sr_data_reg <= ext_value;
                sr_tag_reg  <= in_tag;
            end
        end
    end

`ifdef IMM_EXT_STATS_EN
    logic [15:0] stat_count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_count_reg <= '0;
        end else if (in_accept) begin
            stat_count_reg <= stat_count_reg + 16'd1;
        end
    end

    assign stat_count = stat_count_reg;
`else
    assign stat_count = '0;
`endif

endmodule : imm_extend_pipe

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: vector table plus directed multi-cycle sequences.
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic [15:0] stat_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [4:0]  tag;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    imm_extend_pipe #(
        .IN_W  (16),
        .OUT_W (32),
        .TAG_W (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_imm     (in_imm),
        .in_mode    (in_mode),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .stat_count (stat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end else begin
            $display("ok   %s value=%0h", name, actual);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{16'h8001, 2'b00, 5'd10, 32'hFFFF8001};
        vecs[1] = '{16'h8001, 2'b01, 5'd11, 32'h00008001};
        vecs[2] = '{16'h8001, 2'b10, 5'd12, 32'h80010000};
        vecs[3] = '{16'h8001, 2'b11, 5'd13, 32'hFFFE0004};
        vecs[4] = '{16'hFFFF, 2'b00, 5'd3,  32'hFFFFFFFF};
        vecs[5] = '{16'h0000, 2'b00, 5'd31, 32'h00000000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        @(negedge clk);
        cyc();
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_tag", {27'd0, out_tag}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_stat_count", {16'd0, stat_count}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Vector table: one beat at a time, visible one cycle after acceptance.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_imm   = vecs[i].imm;
            in_mode  = vecs[i].mode;
            in_tag   = vecs[i].tag;
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            cyc();
            in_valid = 1'b0;
            in_mode  = ~vecs[i].mode;
            check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
            check($sformatf("vec%0d_out_tag", i), {27'd0, out_tag}, {27'd0, vecs[i].tag});
            cyc();
            check($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
        end

        // Back-pressure: tags 1,2 fill the buffer, tag 3 waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b01;
        in_imm    = 16'd1;
        in_tag    = 5'd1;
        cyc();
        check("bp_ready_after_1", {31'd0, in_ready}, 32'd1);
        in_imm = 16'd2;
        in_tag = 5'd2;
        cyc();
        check("bp_ready_after_2", {31'd0, in_ready}, 32'd0);
        check("bp_tag_hold_a", {27'd0, out_tag}, 32'd1);
        in_imm = 16'd3;
        in_tag = 5'd3;
        cyc();
        check("bp_still_full", {31'd0, in_ready}, 32'd0);
        check("bp_tag_hold_b", {27'd0, out_tag}, 32'd1);
        check("bp_data_hold", out_data, 32'd1);
        check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        cyc();
        check("bp_rel_tag2", {27'd0, out_tag}, 32'd2);
        check("bp_rel_data2", out_data, 32'd2);
        check("bp_rel_valid2", {31'd0, out_valid}, 32'd1);
        check("bp_rel_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        check("bp_rel_tag3", {27'd0, out_tag}, 32'd3);
        check("bp_rel_data3", out_data, 32'd3);
        check("bp_rel_valid3", {31'd0, out_valid}, 32'd1);
        cyc();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Streaming: one beat per cycle, positive immediates so SIGN == value.
        in_mode  = 2'b00;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_imm = 16'(i + 100);
            in_tag = 5'(i);
            check($sformatf("stream%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            if (i > 0) begin
                check($sformatf("stream%0d_prev_valid", i), {31'd0, out_valid}, 32'd1);
                check($sformatf("stream%0d_prev_tag", i), {27'd0, out_tag}, 32'(i - 1));
                check($sformatf("stream%0d_prev_data", i), out_data, 32'(i + 99));
            end
            cyc();
        end
        in_valid = 1'b0;
        check("stream_last_valid", {31'd0, out_valid}, 32'd1);
        check("stream_last_tag", {27'd0, out_tag}, 32'd9);
        check("stream_last_data", out_data, 32'd109);
        cyc();
        check("stream_drained", {31'd0, out_valid}, 32'd0);

        // Reset while FULL, with a beat offered during reset.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_imm    = 16'hABCD;
        in_tag    = 5'd7;
        cyc();
        in_tag = 5'd8;
        cyc();
        check("rstfull_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n  = 1'b0;
        in_tag = 5'd9;
        cyc();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check("rstfull_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstfull_out_data", out_data, 32'd0);
        check("rstfull_out_tag", {27'd0, out_tag}, 32'd0);
        check("rstfull_in_ready", {31'd0, in_ready}, 32'd1);
        check("rstfull_stat", {16'd0, stat_count}, 32'd0);
        out_ready = 1'b1;
        cyc();
        check("rstfull_no_ghost", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_mode  = 2'b10;
        in_imm   = 16'h7FFF;
        in_tag   = 5'd21;
        cyc();
        in_valid = 1'b0;
        check("fresh_valid", {31'd0, out_valid}, 32'd1);
        check("fresh_data", out_data, 32'h7FFF0000);
        check("fresh_tag", {27'd0, out_tag}, 32'd21);
        cyc();
        check("fresh_no_stale", {31'd0, out_valid}, 32'd0);

`ifdef IMM_EXT_STATS_EN
        rst_n = 1'b0;
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        for (int i = 0; i < 65537; i++) begin
            cyc();
        end
        in_valid = 1'b0;
        check("stat_wrap", {16'd0, stat_count}, 32'd1);
`else
        check("stat_tied_zero", {16'd0, stat_count}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_imm_extend_pipe

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Pipelined, parametrised immediate extender for the ID stage; successor to the combinational 16->32 sign extender. Takes an IN_W immediate plus a 2-bit mode and sideband tag over a valid/ready handshake. Produces a registered OUT_W operand for EX. A 2-entry skid buffer gives full throughput under EX back-pressure.

Parameters:
IN_W, 16, immediate input width (>=2)
OUT_W, 32, extended output width (must be > IN_W; elaboration error otherwise)
TAG_W, 5, sideband tag width (e.g. destination register), passed through unchanged

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_imm  in  IN_W  raw immediate field
in_mode  in  2  00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH
in_tag  in  TAG_W  sideband, forwarded unchanged
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts beat
out_data  out  OUT_W  extended value
out_tag  out  TAG_W  tag of out_data
stat_count  out  16  accepted-beat counter (only with IMM_EXT_STATS_EN; tied 0 otherwise)

Behaviour:
- Extension, from the accepted beat:
  - SIGN: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
  - ZERO: upper bits 0.
  - UPPER: in_imm in bits [OUT_W-1:OUT_W-IN_W], low bits 0.
  - BRANCH: SIGN result shifted left 2, truncated to OUT_W; the top 2 bits are lost.
- Handshake:
  - An input beat transfers when in_valid && in_ready.
  - An output beat transfers when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_tag stay stable.
  - out_valid never deasserts without a transfer.
- Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N with out_valid=1.
- Storage: output register (OR) plus skid register (SR). in_ready = !SR_valid; it is registered-state derived, with no combinational path from out_ready.
- States (occupancy) and transitions:
  - EMPTY: OR and SR invalid.
    - Accept -> ONE.
  - ONE: OR valid.
    - Accept with no drain -> FULL; beat goes to SR.
    - Accept with drain -> ONE; beat goes to OR.
    - Drain only -> EMPTY.
    - Neither -> hold.
  - FULL: OR and SR valid, in_ready=0.
    - Drain -> ONE; SR moves to OR.
    - No drain -> hold.
- Ordering is strict FIFO; there is no dropping or duplication.
- Simultaneous accept and drain in ONE sustains 1 beat/cycle.
- Reset (rst_n=0 at a clock edge):
  - OR and SR valid flags clear; out_valid=0, out_data=0, out_tag=0, stat_count=0.
  - in_ready=1 from the first edge after reset.
  - Reset mid-transfer discards all held beats. Inputs presented during reset are ignored.
- The mode is sampled with its beat; changing in_mode later does not affect stored beats.

Optional Feature:
Macro IMM_EXT_STATS_EN.
- Defined: stat_count increments by 1 per accepted input beat and wraps from 16'hFFFF to 0. It resets to 0.
- Undefined: no counter logic is generated and stat_count is constant 0.
- Datapath behaviour is identical in both builds.

Decomposition:
- Shared package id_pkg holds:
  - mode localparams IMM_SIGN=2'b00, IMM_ZERO=2'b01, IMM_UPPER=2'b10, IMM_BRANCH=2'b11
  - the mode width constant IMM_MODE_W=2
- Sub-module imm_extend_core: purely combinational (in_imm, in_mode) -> OUT_W value. It is instantiated once, in front of the skid buffer, so both registers store extended values.

Test Plan:
1. IN_W=16, OUT_W=32, out_ready=1, four beats with imm 16'h8001:
   - SIGN -> 32'hFFFF8001
   - ZERO -> 32'h00008001
   - UPPER -> 32'h80010000
   - BRANCH -> 32'hFFFE0004
   - Each beat appears 1 cycle after accept.
2. Imm 16'hFFFF and 16'h0000 in SIGN: 16'hFFFF -> 32'hFFFFFFFF; 16'h0000 -> 0. Tags 5'd3 and 5'd31 pass through unchanged.
3. Back-pressure: out_ready=0, three beats tags 1,2,3 offered back-to-back.
   - Tags 1 and 2 accepted; in_ready drops after the second accept.
   - out_tag holds 1.
   - Release out_ready -> tags 1, 2, 3 appear in order with no gaps after the release.
4. Streaming with out_ready=1 and in_valid=1 for 10 cycles: 10 beats out in 10 consecutive cycles, in_ready constantly 1.
5. Reset with FULL occupancy:
   - Next cycle out_valid=0, out_data=0, in_ready=1.
   - A fresh beat afterwards emerges correctly with no stale data.
6. With IMM_EXT_STATS_EN: accept 65537 beats -> stat_count=1 (wrap). Without the macro, stat_count=0 throughout.
